// File: rtl/safety_island_timer_array.sv
// Multi-channel prescaled up-counter array with compare/overflow interrupts behind a register port.
// Latency: register writes commit at the request edge; reads and error are combinational.
// Backpressure: none; ready mirrors valid, so every access completes in its own cycle.
module safety_island_timer_array #(
    parameter int unsigned NumTimers = 2,
    parameter int unsigned CntWidth  = 32,
    parameter int unsigned AddrWidth = 12
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   halt_i,
    input  logic                   reg_valid_i,
    input  logic                   reg_write_i,
    input  logic [AddrWidth-1:0]   reg_addr_i,
    input  logic [31:0]            reg_wdata_i,
    input  logic [3:0]             reg_wstrb_i,
    output logic                   reg_ready_o,
    output logic [31:0]            reg_rdata_o,
    output logic                   reg_error_o,
    output logic [2*NumTimers-1:0] irq_o
);

    localparam int unsigned          IdxWidth  = AddrWidth - 4;
    localparam logic [AddrWidth-1:0] StartAddr = AddrWidth'(12'hFF0);
    localparam logic [AddrWidth-1:0] IdAddr    = AddrWidth'(12'hFF4);
    localparam logic [CntWidth-1:0]  CntMax    = '1;

    logic [31:0]          wmask;
    logic [IdxWidth-1:0]  chan_idx;
    logic [1:0]           reg_off;
    logic                 aligned, chan_hit, start_hit, id_hit, mapped;
    logic                 wr_en, rd_en;
    logic [NumTimers-1:0] start_set;
    logic [31:0]          chan_rdata [NumTimers];

    assign wmask     = {{8{reg_wstrb_i[3]}}, {8{reg_wstrb_i[2]}},
                        {8{reg_wstrb_i[1]}}, {8{reg_wstrb_i[0]}}};
    assign chan_idx  = reg_addr_i[AddrWidth-1:4];
    assign reg_off   = reg_addr_i[3:2];
    assign aligned   = (reg_addr_i[1:0] == 2'b00);
    assign chan_hit  = aligned && (chan_idx < IdxWidth'(NumTimers));
    assign start_hit = aligned && (reg_addr_i == StartAddr);
    assign id_hit    = aligned && (reg_addr_i == IdAddr);
    assign mapped    = chan_hit | start_hit | id_hit;

    assign reg_ready_o = reg_valid_i;
    assign reg_error_o = reg_valid_i & ~mapped;
    assign wr_en       = reg_valid_i & reg_write_i & mapped;
    assign rd_en       = reg_valid_i & ~reg_write_i & mapped;
    assign start_set   = {NumTimers{wr_en & start_hit}}
                       & reg_wdata_i[NumTimers-1:0] & wmask[NumTimers-1:0];

    for (genvar t = 0; t < NumTimers; t++) begin : g_chan
        logic                en_q, mode_q, cmp_ie_q, ovf_ie_q;
        logic                en_d, mode_d, cmp_ie_d, ovf_ie_d;
        logic [7:0]          presc_q, presc_d, pc_q, pc_d;
        logic [CntWidth-1:0] count_q, count_d, cmp_q, cmp_d;
        logic                cmp_flag_q, cmp_flag_d, ovf_flag_q, ovf_flag_d;
        logic                sel, tick, hit_cmp, hit_ovf;
        logic [1:0]          clr;
        logic [CntWidth-1:0] wdata_c, wmask_c;
        logic [31:0]         ctrl_rd;

        assign sel     = wr_en && chan_hit && (chan_idx == IdxWidth'(t));
        assign tick    = en_q && !halt_i && (pc_q == presc_q);
        assign hit_cmp = tick && (count_q == cmp_q);
        assign hit_ovf = tick && !hit_cmp && (count_q == CntMax);
        assign wdata_c = reg_wdata_i[CntWidth-1:0];
        assign wmask_c = wmask[CntWidth-1:0];
        assign clr     = (sel && reg_off == 2'd3 && reg_wstrb_i[0]) ? reg_wdata_i[1:0] : 2'b00;
        assign ctrl_rd = {16'h0, presc_q, 4'h0, ovf_ie_q, cmp_ie_q, mode_q, en_q};

        always_comb begin
            en_d     = en_q;
            mode_d   = mode_q;
            cmp_ie_d = cmp_ie_q;
            ovf_ie_d = ovf_ie_q;
            presc_d  = presc_q;
            pc_d     = pc_q;
            count_d  = count_q;
            cmp_d    = cmp_q;
            if (en_q && !halt_i) begin
                pc_d = tick ? 8'd0 : pc_q + 8'd1;
            end
            if (tick) begin
                count_d = (hit_cmp || hit_ovf) ? '0 : count_q + CntWidth'(1);
            end
            if (hit_cmp && mode_q) begin
                en_d = 1'b0;
            end
            if (sel && reg_off == 2'd0) begin
                if (reg_wstrb_i[0]) begin
                    // A one-shot match in the same cycle still disables the channel.
                    en_d     = reg_wdata_i[0] & ~(hit_cmp & mode_q);
                    mode_d   = reg_wdata_i[1];
                    cmp_ie_d = reg_wdata_i[2];
                    ovf_ie_d = reg_wdata_i[3];
                end
                if (reg_wstrb_i[1]) begin
                    presc_d = reg_wdata_i[15:8];
                end
            end
            if (sel && reg_off == 2'd1) begin
                count_d = (count_q & ~wmask_c) | (wdata_c & wmask_c);
            end
            if (sel && reg_off == 2'd2) begin
                cmp_d = (cmp_q & ~wmask_c) | (wdata_c & wmask_c);
            end
            if (start_set[t]) begin
                en_d = 1'b1;
                pc_d = 8'd0;
            end
            // Hardware set beats a same-cycle write-1-clear.
            cmp_flag_d = (cmp_flag_q & ~clr[0]) | hit_cmp;
            ovf_flag_d = (ovf_flag_q & ~clr[1]) | hit_ovf;
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                en_q       <= 1'b0;
                mode_q     <= 1'b0;
                cmp_ie_q   <= 1'b0;
                ovf_ie_q   <= 1'b0;
                presc_q    <= 8'd0;
                pc_q       <= 8'd0;
                count_q    <= '0;
                cmp_q      <= '0;
                cmp_flag_q <= 1'b0;
                ovf_flag_q <= 1'b0;
            end else begin
                en_q       <= en_d;
                mode_q     <= mode_d;
                cmp_ie_q   <= cmp_ie_d;
                ovf_ie_q   <= ovf_ie_d;
                presc_q    <= presc_d;
                pc_q       <= pc_d;
                count_q    <= count_d;
                cmp_q      <= cmp_d;
                cmp_flag_q <= cmp_flag_d;
                ovf_flag_q <= ovf_flag_d;
            end
        end

        assign chan_rdata[t] = (reg_off == 2'd0) ? ctrl_rd :
                               (reg_off == 2'd1) ? 32'(count_q) :
                               (reg_off == 2'd2) ? 32'(cmp_q) :
                                                   {30'h0, ovf_flag_q, cmp_flag_q};
        assign irq_o[2*t]   = cmp_flag_q & cmp_ie_q;
        assign irq_o[2*t+1] = ovf_flag_q & ovf_ie_q;
    end

    always_comb begin
        reg_rdata_o = 32'h0;
        if (rd_en) begin
            if (id_hit) begin
                reg_rdata_o = {16'h0, 8'(CntWidth), 8'(NumTimers)};
            end
            for (int i = 0; i < NumTimers; i++) begin
                if (chan_hit && chan_idx == IdxWidth'(i)) begin
                    reg_rdata_o = chan_rdata[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_safety_island_timer_array.sv
// Directed bench for safety_island_timer_array: a 2x32-bit instance and a 1x8-bit instance
// share one register bus; expected values go through a scoreboard queue.
module tb_safety_island_timer_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic        write = 1'b0;
    logic [11:0] addr = 12'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        ready_a, ready_b, err_a, err_b;
    logic [31:0] rdata_a, rdata_b;
    logic [3:0]  irq_a;
    logic [1:0]  irq_b;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    safety_island_timer_array #(.NumTimers(2), .CntWidth(32), .AddrWidth(12)) dut (
        .clk_i(clk), .rst_ni(rst_n), .halt_i(halt),
        .reg_valid_i(valid_a), .reg_write_i(write), .reg_addr_i(addr),
        .reg_wdata_i(wdata), .reg_wstrb_i(wstrb),
        .reg_ready_o(ready_a), .reg_rdata_o(rdata_a), .reg_error_o(err_a),
        .irq_o(irq_a)
    );

    safety_island_timer_array #(.NumTimers(1), .CntWidth(8), .AddrWidth(12)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .halt_i(halt),
        .reg_valid_i(valid_b), .reg_write_i(write), .reg_addr_i(addr),
        .reg_wdata_i(wdata), .reg_wstrb_i(wstrb),
        .reg_ready_o(ready_b), .reg_rdata_o(rdata_b), .reg_error_o(err_b),
        .irq_o(irq_b)
    );

    task automatic expect_val(string tag, logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic compare(logic [31:0] obs);
        logic [31:0] e;
        string       t;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_underflow observed=%h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] e);
        expect_val(tag, e);
        compare(obs);
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(bit sel8, logic [11:0] a, logic [31:0] d, logic [3:0] s = 4'hF);
        valid_a = !sel8; valid_b = sel8; write = 1'b1; addr = a; wdata = d; wstrb = s;
        @(posedge clk);
        #1;
        valid_a = 1'b0; valid_b = 1'b0; write = 1'b0; wstrb = 4'h0;
    endtask

    task automatic rd(bit sel8, logic [11:0] a, logic [31:0] e, string tag);
        valid_a = !sel8; valid_b = sel8; write = 1'b0; addr = a;
        expect_val(tag, e);
        #2;
        compare(sel8 ? rdata_b : rdata_a);
        @(posedge clk);
        #1;
        valid_a = 1'b0; valid_b = 1'b0;
    endtask

    task automatic acc(logic [11:0] a, bit w, bit exp_err, string tag);
        valid_a = 1'b1; write = w; addr = a; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        #2;
        chk({tag, "_err"}, 32'(err_a), 32'(exp_err));
        chk({tag, "_rdata"}, rdata_a, 32'h0);
        chk({tag, "_ready"}, 32'(ready_a), 32'h1);
        @(posedge clk);
        #1;
        valid_a = 1'b0; write = 1'b0; wstrb = 4'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        cyc(2);
        rst_n = 1'b1;
        chk("rst_irq_a", 32'(irq_a), 32'h0);
        chk("rst_irq_b", 32'(irq_b), 32'h0);
        chk("rst_err", 32'(err_a), 32'h0);
        chk("rst_rdata", rdata_a, 32'h0);
        chk("rst_ready_idle", 32'(ready_a), 32'h0);
        rd(0, 12'h000, 32'h0, "rst_ctrl0");
        rd(0, 12'h004, 32'h0, "rst_count0");

        // Periodic compare, CMP=4 PRESC=0
        wr(0, 12'h008, 32'd4);
        wr(0, 12'h000, 32'h5);
        cyc(4);
        chk("per_irq_before", 32'(irq_a[0]), 32'h0);
        cyc(1);
        chk("per_irq_rise", 32'(irq_a[0]), 32'h1);
        rd(0, 12'h004, 32'h0, "per_count_after_match");
        wr(0, 12'h00C, 32'h1);
        chk("per_irq_cleared", 32'(irq_a[0]), 32'h0);
        cyc(2);
        chk("per_irq_before2", 32'(irq_a[0]), 32'h0);
        cyc(1);
        chk("per_irq_rise2", 32'(irq_a[0]), 32'h1);
        do_reset();

        // One-shot ch1, CMP=2 PRESC=3
        wr(0, 12'h018, 32'd2);
        wr(0, 12'h010, 32'h307);
        cyc(11);
        chk("os_irq_before", 32'(irq_a[2]), 32'h0);
        cyc(1);
        chk("os_irq_rise", 32'(irq_a[3:2]), 32'h1);
        rd(0, 12'h010, 32'h306, "os_en_cleared");
        rd(0, 12'h014, 32'h0, "os_count0");
        cyc(10);
        rd(0, 12'h014, 32'h0, "os_count_holds");
        rd(0, 12'h01C, 32'h1, "os_status");
        do_reset();

        // Overflow on the 8-bit instance
        wr(1, 12'h004, 32'hFFFF_FF12);
        rd(1, 12'h004, 32'h12, "w8_upper_bits_zero");
        wr(1, 12'h004, 32'hFE);
        wr(1, 12'h008, 32'h10);
        wr(1, 12'h000, 32'h9);
        cyc(1);
        chk("ovf_irq_before", 32'(irq_b), 32'h0);
        cyc(1);
        chk("ovf_irq_rise", 32'(irq_b), 32'h2);
        rd(1, 12'h004, 32'h0, "ovf_count0");
        rd(1, 12'h00C, 32'h2, "ovf_status");
        do_reset();
        wr(1, 12'h004, 32'hFE);
        wr(1, 12'h008, 32'hFF);
        wr(1, 12'h000, 32'hD);
        cyc(2);
        chk("cmpmax_irq", 32'(irq_b), 32'h1);
        rd(1, 12'h00C, 32'h1, "cmpmax_status");
        do_reset();

        // W1C on the exact match edge
        wr(0, 12'h008, 32'd4);
        wr(0, 12'h000, 32'h5);
        cyc(4);
        wr(0, 12'h00C, 32'h1);
        chk("w1c_collide_irq", 32'(irq_a[0]), 32'h1);
        rd(0, 12'h00C, 32'h1, "w1c_collide_status");
        wr(0, 12'h00C, 32'h1);
        chk("w1c_normal_irq", 32'(irq_a[0]), 32'h0);
        do_reset();

        // COUNT write on a tick cycle
        wr(0, 12'h008, 32'h1000);
        wr(0, 12'h000, 32'h1);
        cyc(3);
        wr(0, 12'h004, 32'h100);
        rd(0, 12'h004, 32'h100, "cnt_write_wins");
        rd(0, 12'h004, 32'h101, "cnt_continues");
        do_reset();

        // Partial strobes and lockstep START
        wr(0, 12'h000, 32'hFFFF_FFFF, 4'b0010);
        rd(0, 12'h000, 32'h0000_FF00, "strb_presc_only");
        wr(0, 12'h008, 32'd3);
        wr(0, 12'h018, 32'd3);
        wr(0, 12'h000, 32'h104);
        wr(0, 12'h010, 32'h104);
        wr(0, 12'hFF0, 32'h3, 4'b1110);
        rd(0, 12'h000, 32'h104, "start_masked_noop");
        wr(0, 12'hFF0, 32'h3);
        cyc(7);
        chk("start_irq_before", 32'(irq_a & 4'b0101), 32'h0);
        cyc(1);
        chk("start_irq_aligned", 32'(irq_a & 4'b0101), 32'h5);
        rd(0, 12'hFF0, 32'h0, "start_reads0");
        do_reset();

        // Debug halt for 7 cycles
        wr(0, 12'h008, 32'd9);
        wr(0, 12'h000, 32'h5);
        cyc(3);
        halt = 1'b1;
        rd(0, 12'h004, 32'd3, "halt_count_frozen");
        cyc(6);
        halt = 1'b0;
        rd(0, 12'h004, 32'd3, "halt_count_after");
        cyc(5);
        chk("halt_irq_before", 32'(irq_a[0]), 32'h0);
        cyc(1);
        chk("halt_irq_delayed", 32'(irq_a[0]), 32'h1);
        do_reset();

        // Bus errors and ID
        wr(0, 12'h008, 32'h55);
        acc(12'h002, 1'b1, 1'b1, "misalign_wr");
        acc(12'h002, 1'b0, 1'b1, "misalign_rd");
        acc(12'h020, 1'b1, 1'b1, "badchan_wr");
        acc(12'h020, 1'b0, 1'b1, "badchan_rd");
        acc(12'h800, 1'b1, 1'b1, "unmapped_wr");
        acc(12'h800, 1'b0, 1'b1, "unmapped_rd");
        acc(12'hFF4, 1'b1, 1'b0, "id_wr");
        rd(0, 12'h008, 32'h55, "err_cmp_unchanged");
        rd(0, 12'h000, 32'h0, "err_ctrl_unchanged");
        rd(0, 12'hFF4, 32'h2002, "id_main");
        rd(1, 12'hFF4, 32'h0801, "id_w8");

        // Reset mid-count with a pending interrupt
        wr(0, 12'h008, 32'd2);
        wr(0, 12'h000, 32'h5);
        cyc(3);
        chk("pre_rst_irq", 32'(irq_a[0]), 32'h1);
        do_reset();
        chk("post_rst_irq", 32'(irq_a), 32'h0);
        rd(0, 12'h000, 32'h0, "post_rst_ctrl");
        rd(0, 12'h004, 32'h0, "post_rst_count");
        rd(0, 12'h008, 32'h0, "post_rst_cmp");
        rd(0, 12'h00C, 32'h0, "post_rst_status");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
